// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv memory arbiter: access sizes, FSM encoding
// and the load/store alignment rule.
package riscv_pkg;

    localparam logic [1:0] BY_BYTE = 2'd0;
    localparam logic [1:0] BY_HALF = 2'd1;
    localparam logic [1:0] BY_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    // Size code 3 is illegal and always errors.
    function automatic logic ls_misaligned(input logic [1:0] by, input logic [1:0] addr_lo);
        logic bad;
        unique case (by)
            BY_BYTE: bad = 1'b0;
            BY_HALF: bad = addr_lo[0];
            BY_WORD: bad = (addr_lo != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/arb_prio2.sv
// Two-way fixed-priority picker: LS wins over IF unless IF has been passed over
// MAX_STARVE consecutive times while requesting.
module arb_prio2 #(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic req_if,
    input  logic req_ls,
    output logic sel_ls
);

    localparam int unsigned CntW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_STARVE);

    logic [CntW-1:0] starve_q, starve_d;

    assign sel_ls = req_ls && !(req_if && (starve_q == CntMax));

    always_comb begin
        starve_d = starve_q;
        if (arb_en) begin
            if (!req_if) begin
                starve_d = '0;
            end else if (sel_ls) begin
                if (starve_q != CntMax) begin
                    starve_d = starve_q + CntW'(1);
                end
            end else begin
                starve_d = '0;  // IF granted
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one riscv_mem port between instruction fetch and load/store, one
// access at a time, with alignment checking and per-requester responses.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_by,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_WE,
    output logic        mem_RE,
    output logic [1:0]  mem_by
);

    localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(MEM_LAT - 1);

    arb_state_e      state_q, state_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [31:0]     addr_q, wdata_q;
    logic [1:0]      by_q;
    logic            we_q, is_ls_q, err_q;
    logic [31:0]     if_rdata_q, ls_rdata_q;

    logic        idle, sel_ls, win_bad, access_last;
    logic        rsp_en, rsp_ls;
    logic [31:0] rsp_data;

    assign idle = (state_q == StIdle);

    arb_prio2 #(
        .MAX_STARVE (MAX_STARVE)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .arb_en (idle),
        .req_if (if_req),
        .req_ls (ls_req),
        .sel_ls (sel_ls)
    );

    assign ls_gnt = idle && sel_ls;
    assign if_gnt = idle && if_req && !sel_ls;

    assign win_bad     = ls_gnt ? ls_misaligned(ls_by, ls_addr[1:0]) : (if_addr[1:0] != 2'd0);
    assign access_last = (lat_q == LatLast);

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        rsp_en   = 1'b0;
        rsp_ls   = is_ls_q;
        rsp_data = '0;
        unique case (state_q)
            StIdle: begin
                if (if_gnt || ls_gnt) begin
                    lat_d = '0;
                    if (win_bad) begin
                        state_d = StResp;
                        rsp_en  = 1'b1;
                        rsp_ls  = ls_gnt;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (access_last) begin
                    state_d  = StResp;
                    lat_d    = '0;
                    rsp_en   = 1'b1;
                    rsp_data = we_q ? 32'd0 : mem_data_out;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            lat_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            by_q       <= BY_BYTE;
            we_q       <= 1'b0;
            is_ls_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (if_gnt || ls_gnt) begin
                addr_q  <= ls_gnt ? ls_addr : if_addr;
                wdata_q <= ls_gnt ? ls_wdata : 32'd0;
                by_q    <= ls_gnt ? ls_by : BY_WORD;
                we_q    <= ls_gnt && ls_we;
                is_ls_q <= ls_gnt;
                err_q   <= win_bad;
            end
            // Response data only changes as rvalid rises, so it holds otherwise.
            if (rsp_en) begin
                if (rsp_ls) begin
                    ls_rdata_q <= rsp_data;
                end else begin
                    if_rdata_q <= rsp_data;
                end
            end
        end
    end

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_by      = by_q;
    assign mem_RE      = (state_q == StAccess) && !we_q;
    assign mem_WE      = (state_q == StAccess) && we_q;

    assign if_rvalid = (state_q == StResp) && !is_ls_q;
    assign ls_rvalid = (state_q == StResp) && is_ls_q;
    assign if_err    = if_rvalid && err_q;
    assign ls_err    = ls_rvalid && err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_riscv_mem_arbiter;

    logic clk;
    logic reset;

    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [1:0]  ls_by;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_WE, mem_RE;
    logic [1:0]  mem_by;

    logic        if_req3, if_gnt3, if_rvalid3, if_err3;
    logic [31:0] if_addr3, if_rdata3;
    logic        ls_req3, ls_we3, ls_gnt3, ls_rvalid3, ls_err3;
    logic [1:0]  ls_by3;
    logic [31:0] ls_addr3, ls_wdata3, ls_rdata3;
    logic [31:0] mem_addr3, mem_data_in3, mem_data_out3;
    logic        mem_WE3, mem_RE3;
    logic [1:0]  mem_by3;

    logic [31:0] mem [0:15];

    int n_checks;
    int n_fail;

    assign mem_data_out  = mem_RE  ? mem[mem_addr[5:2]]  : 32'd0;
    assign mem_data_out3 = mem_RE3 ? mem[mem_addr3[5:2]] : 32'd0;

    riscv_mem_arbiter #(
        .MEM_LAT    (1),
        .MAX_STARVE (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_err       (if_err),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_by        (ls_by),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_gnt       (ls_gnt),
        .ls_rvalid    (ls_rvalid),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_WE       (mem_WE),
        .mem_RE       (mem_RE),
        .mem_by       (mem_by)
    );

    riscv_mem_arbiter #(
        .MEM_LAT    (3),
        .MAX_STARVE (4)
    ) dut3 (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req3),
        .if_addr      (if_addr3),
        .if_gnt       (if_gnt3),
        .if_rvalid    (if_rvalid3),
        .if_rdata     (if_rdata3),
        .if_err       (if_err3),
        .ls_req       (ls_req3),
        .ls_we        (ls_we3),
        .ls_by        (ls_by3),
        .ls_addr      (ls_addr3),
        .ls_wdata     (ls_wdata3),
        .ls_gnt       (ls_gnt3),
        .ls_rvalid    (ls_rvalid3),
        .ls_rdata     (ls_rdata3),
        .ls_err       (ls_err3),
        .mem_addr     (mem_addr3),
        .mem_data_in  (mem_data_in3),
        .mem_data_out (mem_data_out3),
        .mem_WE       (mem_WE3),
        .mem_RE       (mem_RE3),
        .mem_by       (mem_by3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps from the grant cycle until a response pulse; lat is cycles from grant.
    task automatic run_access(input bit use3, output int lat, output int re_n, output int we_n);
        bit done;
        lat  = 0;
        re_n = 0;
        we_n = 0;
        done = 1'b0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (use3) begin
                if (mem_RE3) re_n++;
                if (mem_WE3) we_n++;
                done = if_rvalid3 || ls_rvalid3;
            end else begin
                if (mem_RE) re_n++;
                if (mem_WE) we_n++;
                done = if_rvalid || ls_rvalid;
            end
        end
        if (!done) check_eq("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, re_n, we_n, ng, both, rv;
        logic [9:0] order;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'hA0A0_A0A0;
        mem[1] = 32'hB1B1_B1B1;
        mem[2] = 32'h1234_5678;
        mem[3] = 32'h0BAD_F00D;
        mem[4] = 32'hDEAD_BEEF;

        reset   = 1'b0;
        if_req  = 1'b0; if_addr  = '0;
        ls_req  = 1'b0; ls_we    = 1'b0; ls_by  = 2'd0; ls_addr  = '0; ls_wdata  = '0;
        if_req3 = 1'b0; if_addr3 = '0;
        ls_req3 = 1'b0; ls_we3   = 1'b0; ls_by3 = 2'd0; ls_addr3 = '0; ls_wdata3 = '0;

        repeat (2) tick();
        check_eq("rst_mem_re", mem_RE, 0);
        check_eq("rst_mem_we", mem_WE, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_ls_rvalid", ls_rvalid, 0);
        check_eq("rst_ls_rdata", ls_rdata, 0);
        reset = 1'b1;
        tick();

        // Load word @0x10: gnt T, mem_RE T+1, rvalid T+2.
        ls_req = 1'b1; ls_we = 1'b0; ls_by = 2'd2; ls_addr = 32'h10;
        #1;
        check_eq("ld_gnt", ls_gnt, 1);
        check_eq("ld_if_gnt", if_gnt, 0);
        tick();
        ls_req = 1'b0;
        check_eq("ld_re", mem_RE, 1);
        check_eq("ld_gnt_busy", ls_gnt, 0);
        check_eq("ld_addr", mem_addr, 32'h10);
        check_eq("ld_by", mem_by, 2);
        tick();
        check_eq("ld_rvalid", ls_rvalid, 1);
        check_eq("ld_rdata", ls_rdata, 32'hDEAD_BEEF);
        check_eq("ld_err", ls_err, 0);
        check_eq("ld_re_off", mem_RE, 0);
        tick();
        check_eq("ld_rvalid_pulse", ls_rvalid, 0);
        check_eq("ld_rdata_hold", ls_rdata, 32'hDEAD_BEEF);

        // Misaligned word and illegal size: response next cycle, no strobe.
        ls_req = 1'b1; ls_we = 1'b0; ls_by = 2'd2; ls_addr = 32'h6;
        #1;
        check_eq("mis_gnt", ls_gnt, 1);
        run_access(1'b0, lat, re_n, we_n);
        ls_req = 1'b0;
        check_eq("mis_lat", lat, 1);
        check_eq("mis_strobe", re_n + we_n, 0);
        check_eq("mis_err", ls_err, 1);
        check_eq("mis_rdata", ls_rdata, 0);
        tick();
        ls_req = 1'b1; ls_by = 2'd3; ls_addr = 32'h0;
        #1;
        run_access(1'b0, lat, re_n, we_n);
        ls_req = 1'b0;
        check_eq("ill_lat", lat, 1);
        check_eq("ill_strobe", re_n + we_n, 0);
        check_eq("ill_err", ls_err, 1);
        tick();
        if_req = 1'b1; if_addr = 32'h2;
        #1;
        check_eq("if_mis_gnt", if_gnt, 1);
        run_access(1'b0, lat, re_n, we_n);
        if_req = 1'b0;
        check_eq("if_mis_lat", lat, 1);
        check_eq("if_mis_err", if_err, 1);
        check_eq("if_mis_strobe", re_n, 0);
        tick();

        // Byte store @0x3: WE for exactly one cycle, ack with rdata 0.
        ls_req = 1'b1; ls_we = 1'b1; ls_by = 2'd0; ls_addr = 32'h3; ls_wdata = 32'd5;
        #1;
        check_eq("st_gnt", ls_gnt, 1);
        tick();
        ls_req = 1'b0;
        check_eq("st_we", mem_WE, 1);
        check_eq("st_re", mem_RE, 0);
        check_eq("st_by", mem_by, 0);
        check_eq("st_addr", mem_addr, 32'h3);
        check_eq("st_wdata", mem_data_in, 32'd5);
        tick();
        check_eq("st_we_off", mem_WE, 0);
        check_eq("st_rvalid", ls_rvalid, 1);
        check_eq("st_rdata", ls_rdata, 0);
        check_eq("st_err", ls_err, 0);
        tick();

        // Both requesting continuously: LS x4 then IF, repeating.
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b0; ls_by = 2'd2; ls_addr = 32'h10;
        order = '0; ng = 0; both = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            #1;
            if (if_gnt || ls_gnt) begin
                if (if_gnt) order[ng] = 1'b1;
                if (if_gnt && ls_gnt) both++;
                ng++;
            end
            tick();
        end
        if_req = 1'b0; ls_req = 1'b0;
        check_eq("arb_ngrants", ng, 10);
        check_eq("arb_order", 32'(order), 32'h210);
        check_eq("arb_both", both, 0);
        repeat (4) tick();

        // Reset during a load access: strobe drops at once, no response.
        ls_req = 1'b1; ls_we = 1'b0; ls_by = 2'd2; ls_addr = 32'hC;
        #1;
        check_eq("rst_ld_gnt", ls_gnt, 1);
        tick();
        ls_req = 1'b0;
        check_eq("rst_ld_re", mem_RE, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_async_re", mem_RE, 0);
        check_eq("rst_async_addr", mem_addr, 0);
        rv = 0;
        repeat (3) begin
            tick();
            if (ls_rvalid || if_rvalid) rv++;
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            if (ls_rvalid || if_rvalid) rv++;
        end
        check_eq("rst_no_rvalid", rv, 0);
        if_req = 1'b1; if_addr = 32'h8;
        #1;
        check_eq("post_rst_gnt", if_gnt, 1);
        run_access(1'b0, lat, re_n, we_n);
        if_req = 1'b0;
        check_eq("post_rst_lat", lat, 2);
        check_eq("post_rst_rvalid", if_rvalid, 1);
        check_eq("post_rst_rdata", if_rdata, 32'h1234_5678);
        check_eq("post_rst_err", if_err, 0);
        tick();

        // MEM_LAT=3 back-to-back fetches: rvalid at T+4, next gnt at T+5.
        if_req3 = 1'b1; if_addr3 = 32'h0;
        #1;
        check_eq("l3_gnt0", if_gnt3, 1);
        tick();
        if_addr3 = 32'h4;
        lat  = 1;
        re_n = mem_RE3 ? 1 : 0;
        while (!if_rvalid3 && lat < 20) begin
            tick();
            lat++;
            if (mem_RE3) re_n++;
        end
        check_eq("l3_lat0", lat, 4);
        check_eq("l3_re0", re_n, 3);
        check_eq("l3_rdata0", if_rdata3, 32'hA0A0_A0A0);
        check_eq("l3_no_gnt_resp", if_gnt3, 0);
        tick();
        check_eq("l3_gnt1", if_gnt3, 1);
        run_access(1'b1, lat, re_n, we_n);
        if_req3 = 1'b0;
        check_eq("l3_lat1", lat, 4);
        check_eq("l3_rdata1", if_rdata3, 32'hB1B1_B1B1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
